fibonacci_checker: RTL and testbench
====================================

# fibonacci_checker

Sequence checker that consumes a valid/ready stream of Fibonacci terms, as emitted by the team's Fibonacci generator, and verifies that every term equals the sum of the two preceding terms. It hunts for alignment, declares lock after a run of consecutive correct terms, and flags and counts every break in the sequence. It sits at the generator output as a self-check monitor and as the consuming end of the generator's data path.

## Interface
- `WIDTH`, 5: data width of a term.
- `CNT_W`, 8: width of the match and error counters.
- `LOCK_N`, 2: consecutive matches required to assert `locked` (1..15).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous restart to the empty state; counters zeroed.
- `in_valid` in 1: `in_data` holds a term.
- `in_data` in WIDTH: term value, unsigned.
- `in_ready` out 1: a term is accepted on a rising edge when `in_valid & in_ready`.
- `locked` out 1: sequence tracked with at least LOCK_N consecutive matches.
- `err_pulse` out 1: one-cycle strobe on each mismatch while locked.
- `overflow` out 1: next expected term exceeds WIDTH bits; the checker has stopped.
- `match_count` out CNT_W: number of matching terms, saturating.
- `err_count` out CNT_W: number of `err_pulse` events, saturating.

## Operation
- History registers: `f1` (most recent accepted term) and `f2` (the term before it). `expected = f1 + f2`, computed WIDTH+1 bits wide.
- **EMPTY**: on accept, `f1 <= in_data`; go to ONE.
- **ONE**: on accept, shift (`f2 <= f1`, `f1 <= in_data`); run = 0; go to HUNT.
- **HUNT**: on accept, compare `in_data` with `expected`, then shift.
  - Match: run++, `match_count++`. If run reaches LOCK_N, go to LOCKED.
  - Mismatch: run = 0. No `err_pulse`.
- **LOCKED**: on accept, compare `in_data` with `expected`, then shift.
  - Match: `match_count++`.
  - Mismatch: `err_pulse`, `err_count++`, run = 0, go to HUNT.
- **END** (overflow state): entered from HUNT or LOCKED when `expected[WIDTH]` is 1 after a shift, i.e. the next term cannot be represented.
  - `in_ready = 0`, `overflow = 1`, `locked` holds its last value.
  - Exit only via `clear` or `reset`.
- `in_ready = (state != END)`. It is 1 during and immediately after reset.
- Counters saturate at all-ones and never wrap.
- `clear` has priority over a same-cycle accept; that term is dropped.

## Timing
- Reset values: state EMPTY; `f1`, `f2` and run = 0; `locked`, `err_pulse`, `overflow`, `match_count`, `err_count` = 0.
- All outputs except `in_ready` are registered. They reflect an accepted term on the following cycle (latency 1).
- `in_ready` is combinational from state only, with no path from `in_valid`. It drops the cycle after the term that causes overflow is accepted.
- Back-to-back accepts are supported at one term per cycle. Gaps in `in_valid` hold all state.
- `err_pulse` is high for exactly one cycle per mismatch, including consecutive mismatches on consecutive cycles.
- Reset asserted mid-stream takes effect immediately and asynchronously. There is no partial update.

## Configuration
- `FIB_CHK_WRAP_EN` defined:
  - `expected` is taken modulo 2^WIDTH.
  - END is never entered and `overflow` is tied to 0.
  - Checking continues indefinitely on the wrapped sequence.
- Not defined: overflow behaviour is as described under Operation.

## Structure
- Package `fib_pkg` holds:
  - the state enum typedef `fib_chk_state_t` (EMPTY, ONE, HUNT, LOCKED, END);
  - default constants for WIDTH, CNT_W and LOCK_N.
- One sub-module, `sat_counter`: parameterised CNT_W saturating incrementer with synchronous clear and async active-low reset. It is instantiated twice, for matches and for errors.

## Test plan
- Reset, then terms 1,1,2,3,5,8 back-to-back:
  - `locked` = 1 the cycle after 3 is accepted;
  - `match_count` = 4 after 8;
  - `err_count` = 0.
- Locked stream 1,1,2,3,5 then 9 then 14:
  - `err_pulse` for one cycle after 9, `err_count` = 1, `locked` = 0;
  - 14 (= 5+9) matches, run = 1.
- Terms 1,1,2,3,5,8,13,21 without `FIB_CHK_WRAP_EN`:
  - after 21 is accepted (13+21 = 34 > 31), `overflow` = 1 and `in_ready` = 0;
  - later terms are not accepted.
- Same stream with `FIB_CHK_WRAP_EN` defined, then term 2 (34 mod 32):
  - match, `locked` stays 1, `overflow` = 0.
- `clear` and `in_valid` high in the same cycle mid-stream:
  - state EMPTY, counters 0, the term is not counted;
  - the next two terms re-prime the history.
- `reset` pulled low while LOCKED with `in_valid` stalled, then released:
  - all outputs at reset values, `in_ready` = 1.

Source files
------------

// File: rtl/fibonacci_checker_pkg.sv
// Shared types and default sizing for the Fibonacci sequence checker.
package fib_pkg;

  // Checker progress: priming the history, hunting for alignment,
  // tracking a locked sequence, and stopped after overflow.
  typedef enum logic [2:0] {
    EMPTY  = 3'd0,
    ONE    = 3'd1,
    HUNT   = 3'd2,
    LOCKED = 3'd3,
    END    = 3'd4
  } fib_chk_state_t;

  localparam int DEF_WIDTH  = 5;
  localparam int DEF_CNT_W  = 8;
  localparam int DEF_LOCK_N = 2;

endpackage

// File: rtl/fibonacci_checker_sat_counter.sv
// Saturating event counter: counts up on inc, sticks at all-ones,
// synchronous clear, asynchronous active-low reset.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  // Count register: clear wins over increment; never wraps past all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/fibonacci_checker.sv
// Fibonacci sequence checker: consumes a valid/ready stream of terms,
// checks each against the sum of the two previous ones, locks after
// LOCK_N consecutive matches and flags/counts breaks while locked.
// Build option FIB_CHK_WRAP_EN: expected term is taken modulo 2^WIDTH
// and the overflow stop state is never entered.
module fibonacci_checker
  import fib_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int LOCK_N = DEF_LOCK_N
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             locked,
  output logic             err_pulse,
  output logic             overflow,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int RUN_W = 4;
  localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_N);

  fib_chk_state_t   state_reg, state_next;
  logic [WIDTH-1:0] f1_reg, f1_next;
  logic [WIDTH-1:0] f2_reg, f2_next;
  logic [RUN_W-1:0] run_reg, run_next;
  logic             locked_reg, locked_next;
  logic             err_pulse_reg, err_pulse_next;
  logic             accept;
  logic             term_match;
  logic             next_over;
  logic [1:0]       cnt_inc;     // [0] match, [1] error
  logic [CNT_W-1:0] cnt_val [2];

`ifdef FIB_CHK_WRAP_EN
  logic [WIDTH-1:0] expected;
  assign expected   = f1_reg + f2_reg;
  assign term_match = (in_data == expected);
  assign next_over  = 1'b0;
  assign overflow   = 1'b0;
`else
  logic [WIDTH:0] expected;
  logic [WIDTH:0] next_sum;
  logic           overflow_reg;
  assign expected   = {1'b0, f1_reg} + {1'b0, f2_reg};
  assign term_match = ({1'b0, in_data} == expected);
  // Sum of the history as it will look after this term is shifted in.
  assign next_sum   = {1'b0, in_data} + {1'b0, f1_reg};
  assign next_over  = (next_sum > {1'b0, {WIDTH{1'b1}}});

  // Overflow flag mirrors residence in the stop state, registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) overflow_reg <= 1'b0;
    else        overflow_reg <= (state_next == END);
  end
  assign overflow = overflow_reg;
`endif

  // Ready depends on state only, never on in_valid.
  assign in_ready = (state_reg != END);
  assign accept   = in_valid & in_ready;

  // State and history registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= EMPTY;
      f1_reg        <= '0;
      f2_reg        <= '0;
      run_reg       <= '0;
      locked_reg    <= 1'b0;
      err_pulse_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      f1_reg        <= f1_next;
      f2_reg        <= f2_next;
      run_reg       <= run_next;
      locked_reg    <= locked_next;
      err_pulse_reg <= err_pulse_next;
    end
  end

  // Next-state, history shift, run tracking and counter strobes.
  always_comb begin
    state_next     = state_reg;
    f1_next        = f1_reg;
    f2_next        = f2_reg;
    run_next       = run_reg;
    locked_next    = locked_reg;
    err_pulse_next = 1'b0;
    cnt_inc        = 2'b00;
    if (clear) begin
      // Clear drops any term offered in the same cycle.
      state_next  = EMPTY;
      f1_next     = '0;
      f2_next     = '0;
      run_next    = '0;
      locked_next = 1'b0;
    end else if (accept) begin
      case (state_reg)
        EMPTY: begin
          f1_next    = in_data;
          state_next = ONE;
        end
        ONE: begin
          f2_next    = f1_reg;
          f1_next    = in_data;
          run_next   = '0;
          state_next = HUNT;
        end
        HUNT: begin
          f2_next = f1_reg;
          f1_next = in_data;
          if (term_match) begin
            run_next   = run_reg + RUN_W'(1);
            cnt_inc[0] = 1'b1;
            if (run_next == LOCK_RUN) begin
              state_next  = LOCKED;
              locked_next = 1'b1;
            end
          end else begin
            run_next = '0;
          end
          if (next_over) state_next = END;
        end
        LOCKED: begin
          f2_next = f1_reg;
          f1_next = in_data;
          if (term_match) begin
            cnt_inc[0] = 1'b1;
          end else begin
            err_pulse_next = 1'b1;
            cnt_inc[1]     = 1'b1;
            run_next       = '0;
            locked_next    = 1'b0;
            state_next     = HUNT;
          end
          if (next_over) state_next = END;
        end
        default: ;
      endcase
    end
  end

  // Match counter (index 0) and error counter (index 1).
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .inc   (cnt_inc[gi]),
      .count (cnt_val[gi])
    );
  end

  assign match_count = cnt_val[0];
  assign err_count   = cnt_val[1];
  assign locked      = locked_reg;
  assign err_pulse   = err_pulse_reg;

endmodule

// File: tb/tb_fibonacci_checker.sv
// Directed testbench for fibonacci_checker (WIDTH=5, CNT_W=8, LOCK_N=2).
module tb_fibonacci_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [4:0] in_data = '0;
  logic       in_ready;
  logic       locked;
  logic       err_pulse;
  logic       overflow;
  logic [7:0] match_count;
  logic [7:0] err_count;

  int checks = 0;
  int passes = 0;

  fibonacci_checker #(.WIDTH(5), .CNT_W(8), .LOCK_N(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .overflow    (overflow),
    .match_count (match_count),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  // Offer one term for one cycle; returns 1 ns after the sampling edge.
  task automatic put(input logic [4:0] d);
    logic acc;
    in_valid = 1'b1;
    in_data  = d;
    acc      = in_ready;
    @(posedge clk);
    #1;
    $display("term %0d offered, ready=%0b -> locked=%0b err=%0b ovf=%0b mc=%0d ec=%0d",
             d, acc, locked, err_pulse, overflow, match_count, err_count);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic restart();
    in_valid = 1'b0;
    clear    = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL rst_ready: got %0b want 1", in_ready); else passes++;
    checks++; if (locked !== 1'b0) $display("FAIL rst_locked: got %0b want 0", locked); else passes++;
    checks++; if (overflow !== 1'b0 || err_pulse !== 1'b0) $display("FAIL rst_flags: got ovf=%0b err=%0b want 0/0", overflow, err_pulse); else passes++;
    checks++; if (match_count !== 8'd0 || err_count !== 8'd0) $display("FAIL rst_counts: got %0d/%0d want 0/0", match_count, err_count); else passes++;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL rst_ready_after: got %0b want 1", in_ready); else passes++;
  endtask

  task automatic test_lock();
    restart();
    put(5'd1); put(5'd1); put(5'd2);
    checks++; if (locked !== 1'b0) $display("FAIL lock_early: got %0b want 0", locked); else passes++;
    put(5'd3);
    checks++; if (locked !== 1'b1) $display("FAIL lock_after3: got %0b want 1", locked); else passes++;
    checks++; if (match_count !== 8'd2) $display("FAIL lock_mc3: got %0d want 2", match_count); else passes++;
    put(5'd5);
    idle(3);
    checks++; if (locked !== 1'b1 || match_count !== 8'd3) $display("FAIL lock_gap: got locked=%0b mc=%0d want 1/3", locked, match_count); else passes++;
    put(5'd8);
    idle(1);
    checks++; if (match_count !== 8'd4) $display("FAIL lock_mc8: got %0d want 4", match_count); else passes++;
    checks++; if (err_count !== 8'd0) $display("FAIL lock_ec: got %0d want 0", err_count); else passes++;
  endtask

  task automatic test_mismatch();
    restart();
    put(5'd1); put(5'd1); put(5'd2); put(5'd3); put(5'd5);
    put(5'd9);
    checks++; if (err_pulse !== 1'b1) $display("FAIL mm_pulse: got %0b want 1", err_pulse); else passes++;
    checks++; if (err_count !== 8'd1) $display("FAIL mm_ec: got %0d want 1", err_count); else passes++;
    checks++; if (locked !== 1'b0) $display("FAIL mm_unlock: got %0b want 0", locked); else passes++;
    put(5'd14);
    checks++; if (err_pulse !== 1'b0) $display("FAIL mm_pulse_len: got %0b want 0", err_pulse); else passes++;
    checks++; if (match_count !== 8'd4 || locked !== 1'b0) $display("FAIL mm_rematch: got mc=%0d locked=%0b want 4/0", match_count, locked); else passes++;
    put(5'd0);   // expected 23: mismatch while hunting, silent
    checks++; if (err_pulse !== 1'b0 || err_count !== 8'd1) $display("FAIL mm_hunt_silent: got err=%0b ec=%0d want 0/1", err_pulse, err_count); else passes++;
    idle(1);
  endtask

  task automatic test_overflow();
    restart();
    put(5'd1); put(5'd1); put(5'd2); put(5'd3); put(5'd5); put(5'd8); put(5'd13);
    checks++; if (in_ready !== 1'b1 || overflow !== 1'b0) $display("FAIL ovf_pre: got ready=%0b ovf=%0b want 1/0", in_ready, overflow); else passes++;
    put(5'd21);
    checks++; if (locked !== 1'b1 || match_count !== 8'd6) $display("FAIL ovf_21: got locked=%0b mc=%0d want 1/6", locked, match_count); else passes++;
`ifdef FIB_CHK_WRAP_EN
    checks++; if (overflow !== 1'b0 || in_ready !== 1'b1) $display("FAIL wrap_noovf: got ovf=%0b ready=%0b want 0/1", overflow, in_ready); else passes++;
    put(5'd2);   // (13+21) mod 32
    checks++; if (match_count !== 8'd7 || locked !== 1'b1 || overflow !== 1'b0) $display("FAIL wrap_match: got mc=%0d locked=%0b ovf=%0b want 7/1/0", match_count, locked, overflow); else passes++;
`else
    checks++; if (overflow !== 1'b1 || in_ready !== 1'b0) $display("FAIL ovf_stop: got ovf=%0b ready=%0b want 1/0", overflow, in_ready); else passes++;
    put(5'd2); put(5'd2); put(5'd2);
    checks++; if (match_count !== 8'd6 || overflow !== 1'b1 || in_ready !== 1'b0) $display("FAIL ovf_held: got mc=%0d ovf=%0b ready=%0b want 6/1/0", match_count, overflow, in_ready); else passes++;
    checks++; if (locked !== 1'b1 || err_count !== 8'd0) $display("FAIL ovf_locked_hold: got locked=%0b ec=%0d want 1/0", locked, err_count); else passes++;
`endif
    idle(1);
    restart();
    checks++; if (overflow !== 1'b0 || in_ready !== 1'b1 || match_count !== 8'd0) $display("FAIL ovf_clear: got ovf=%0b ready=%0b mc=%0d want 0/1/0", overflow, in_ready, match_count); else passes++;
  endtask

  task automatic test_clear();
    restart();
    put(5'd1); put(5'd1); put(5'd2); put(5'd3);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 5'd5;
    @(posedge clk);
    #1;
    clear = 1'b0;
    checks++; if (locked !== 1'b0 || match_count !== 8'd0 || err_count !== 8'd0) $display("FAIL clr_state: got locked=%0b mc=%0d ec=%0d want 0/0/0", locked, match_count, err_count); else passes++;
    put(5'd2); put(5'd7);   // 7 == 5+2 would match if the dropped 5 had been kept
    checks++; if (match_count !== 8'd0) $display("FAIL clr_reprime: got %0d want 0", match_count); else passes++;
    put(5'd9);
    checks++; if (match_count !== 8'd1 || locked !== 1'b0) $display("FAIL clr_first: got mc=%0d locked=%0b want 1/0", match_count, locked); else passes++;
    idle(1);
  endtask

  task automatic test_reset_mid();
    restart();
    put(5'd1); put(5'd1); put(5'd2); put(5'd3);
    in_valid = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    checks++; if (locked !== 1'b0 || match_count !== 8'd0 || in_ready !== 1'b1) $display("FAIL async_rst: got locked=%0b mc=%0d ready=%0b want 0/0/1", locked, match_count, in_ready); else passes++;
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (locked !== 1'b0 || err_pulse !== 1'b0 || overflow !== 1'b0 || err_count !== 8'd0 || in_ready !== 1'b1) $display("FAIL rst_release: got locked=%0b err=%0b ovf=%0b ec=%0d ready=%0b want 0/0/0/0/1", locked, err_pulse, overflow, err_count, in_ready); else passes++;
    put(5'd1); put(5'd1); put(5'd2);
    checks++; if (match_count !== 8'd1) $display("FAIL rst_restream: got %0d want 1", match_count); else passes++;
    idle(1);
  endtask

  initial begin
    test_reset();
    test_lock();
    test_mismatch();
    test_overflow();
    test_clear();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
